// File: rtl/act_pwq_pipe.sv
// rtl/act_pwq_pipe.sv - four-stage fixed-point tanh/sigmoid/relu/identity activation pipeline
// Shared piecewise-quadratic tanh core; sigmoid reuses it as 0.5*tanh(x/2)+0.5.
module act_pwq_pipe #(
   parameter int INT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 16,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [1:0]                           in_mode,
   input  logic [TAG_WIDTH-1:0]                 in_tag,
   input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] x,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [TAG_WIDTH-1:0]                 out_tag,
   output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] y,
   output logic                                 sat
);

   localparam int  W     = INT_WIDTH + FRAC_WIDTH;
   localparam int  PW    = 2 * W;
   localparam real SCALE = 2.0 ** FRAC_WIDTH;

   localparam logic [1:0] MODE_TANH = 2'd0;
   localparam logic [1:0] MODE_SIG  = 2'd1;
   localparam logic [1:0] MODE_RELU = 2'd2;
   localparam logic [1:0] MODE_ID   = 2'd3;

   // Constants rounded to nearest at the configured fractional precision.
   localparam logic signed [W-1:0] K_A    = W'($rtoi(1.52     * SCALE + 0.5));
   localparam logic signed [W-1:0] K_B    = W'($rtoi(2.57     * SCALE + 0.5));
   localparam logic signed [W-1:0] K_M1   = W'($rtoi(0.27162  * SCALE + 0.5));
   localparam logic signed [W-1:0] K_C1   = W'($rtoi(1.0      * SCALE + 0.5));
   localparam logic signed [W-1:0] K_D1   = W'($rtoi(0.016    * SCALE + 0.5));
   localparam logic signed [W-1:0] K_M2   = W'($rtoi(0.084785 * SCALE + 0.5));
   localparam logic signed [W-1:0] K_C2   = W'($rtoi(0.42654  * SCALE + 0.5));
   localparam logic signed [W-1:0] K_D2   = W'($rtoi(0.4519   * SCALE + 0.5));
   localparam logic signed [W-1:0] K_ONE  = W'($rtoi(1.0      * SCALE + 0.5));
   localparam logic signed [W-1:0] K_HALF = W'($rtoi(0.5      * SCALE + 0.5));

   localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {REG_R1, REG_R2, REG_R3} region_t;

   function automatic logic signed [PW-1:0] ext(input logic signed [W-1:0] v);
      return {{W{v[W-1]}}, v};
   endfunction

   function automatic logic ovf(input logic signed [PW-1:0] v);
      return (v > ext(W_MAX)) || (v < ext(W_MIN));
   endfunction

   function automatic logic signed [W-1:0] clamp(input logic signed [PW-1:0] v);
      if (v > ext(W_MAX))      return W_MAX;
      else if (v < ext(W_MIN)) return W_MIN;
      else                     return v[W-1:0];
   endfunction

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // S1: sign/magnitude of the tanh argument
   logic                 v1, s1, sat1;
   logic [1:0]           mode1;
   logic [TAG_WIDTH-1:0] tag1;
   logic signed [W-1:0]  x1, a1;
   logic signed [W-1:0]  u_c, a_c;
   logic                 s_c, sat_c;

   always_comb begin
      u_c   = (in_mode == MODE_SIG) ? (x >>> 1) : x;
      s_c   = u_c[W-1];
      sat_c = 1'b0;
      a_c   = s_c ? -u_c : u_c;
      if (u_c == W_MIN) begin
         a_c   = W_MAX;
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0; s1 <= 1'b0; sat1 <= 1'b0; mode1 <= '0;
         tag1 <= '0; x1 <= '0; a1 <= '0;
      end else if (adv) begin
         v1 <= in_valid; s1 <= s_c; sat1 <= sat_c; mode1 <= in_mode;
         tag1 <= in_tag; x1 <= x; a1 <= a_c;
      end
   end

   // S2: square of the magnitude and region select
   logic                 v2, s2, sat2;
   logic [1:0]           mode2;
   logic [TAG_WIDTH-1:0] tag2;
   logic signed [W-1:0]  x2, a2, p2;
   region_t              r2;
   logic signed [PW-1:0] p_full, p_shift;
   region_t              r_c;

   always_comb begin
      p_full  = ext(a1) * ext(a1);
      p_shift = p_full >>> FRAC_WIDTH;
      if (a1 <= K_A)      r_c = REG_R1;
      else if (a1 <= K_B) r_c = REG_R2;
      else                r_c = REG_R3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2 <= 1'b0; s2 <= 1'b0; sat2 <= 1'b0; mode2 <= '0; tag2 <= '0;
         x2 <= '0; a2 <= '0; p2 <= '0; r2 <= REG_R1;
      end else if (adv) begin
         v2 <= v1; s2 <= s1; sat2 <= sat1 | ovf(p_shift); mode2 <= mode1; tag2 <= tag1;
         x2 <= x1; a2 <= a1; p2 <= clamp(p_shift); r2 <= r_c;
      end
   end

   // S3: quadratic segment evaluation
   logic                 v3, s3, sat3;
   logic [1:0]           mode3;
   logic [TAG_WIDTH-1:0] tag3;
   logic signed [W-1:0]  x3, t3;
   logic signed [W-1:0]  kc, km, kd, t_c;
   logic signed [PW-1:0] sum_c;
   logic                 tovf_c;

   always_comb begin
      kc = K_C1; km = K_M1; kd = K_D1;
      if (r2 == REG_R2) begin
         kc = K_C2; km = K_M2; kd = K_D2;
      end
      sum_c  = ((ext(kc) * ext(a2)) >>> FRAC_WIDTH)
             - ((ext(km) * ext(p2)) >>> FRAC_WIDTH)
             + ext(kd);
      t_c    = (r2 == REG_R3) ? K_ONE : clamp(sum_c);
      tovf_c = (r2 == REG_R3) ? 1'b0 : ovf(sum_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3 <= 1'b0; s3 <= 1'b0; sat3 <= 1'b0; mode3 <= '0; tag3 <= '0;
         x3 <= '0; t3 <= '0;
      end else if (adv) begin
         v3 <= v2; s3 <= s2; sat3 <= sat2 | tovf_c; mode3 <= mode2; tag3 <= tag2;
         x3 <= x2; t3 <= t_c;
      end
   end

   // S4: mode-specific output shaping
   logic signed [PW-1:0] nt_c, sg_c;
   logic signed [W-1:0]  y_c;
   logic                 sat_out_c;

   always_comb begin
      nt_c      = s3 ? -ext(t3) : ext(t3);
      sg_c      = ext(K_HALF) + (nt_c >>> 1);
      y_c       = x3;
      sat_out_c = 1'b0;
      case (mode3)
         MODE_TANH: begin
            y_c       = clamp(nt_c);
            sat_out_c = sat3 | ovf(nt_c);
         end
         MODE_SIG: begin
            y_c       = clamp(sg_c);
            sat_out_c = sat3 | ovf(sg_c);
         end
         MODE_RELU: y_c = x3[W-1] ? '0 : x3;
         MODE_ID:   y_c = x3;
         default:   y_c = x3;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0; out_tag <= '0; y <= '0; sat <= 1'b0;
      end else if (adv) begin
         out_valid <= v3; out_tag <= tag3; y <= y_c; sat <= sat_out_c;
      end
   end

endmodule

// File: tb/tb_act_pwq_pipe.sv
// tb/tb_act_pwq_pipe.sv - directed self-checking bench for act_pwq_pipe
module tb_act_pwq_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_mode;
   logic [7:0]  in_tag;
   logic [31:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_tag;
   logic [31:0] y;
   logic        sat;

   int passed = 0;
   int total  = 0;

   act_pwq_pipe #(.INT_WIDTH(16), .FRAC_WIDTH(16), .TAG_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .y(y), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp_v);
   endtask

   // One isolated sample: checks acceptance, 4-cycle latency, result and single emission.
   task automatic run_one(input string name, input logic [1:0] mode, input logic [7:0] tag,
                          input logic [31:0] xv, input logic [31:0] ey, input logic es);
      int lat;
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = mode;
      in_tag    = tag;
      x         = xv;
      out_ready = 1'b1;
      #1 check({name, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, lat, 4);
      check({name, "_y"}, y, ey);
      check({name, "_sat"}, sat, es);
      check({name, "_tag"}, out_tag, tag);
      @(negedge clk);
      check({name, "_single"}, out_valid, 0);
   endtask

   logic [1:0]  bp_mode [10];
   logic [31:0] bp_x    [10];
   logic [31:0] bp_y    [10];
   logic [7:0]  lfsr;
   logic        held;
   logic [31:0] held_y;
   logic [7:0]  held_tag;
   int          tx, rx, extra;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_tag = 8'd0; x = 32'd0; out_ready = 1'b1;

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_sat", sat, 0);
      check("rst_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      run_one("tanh_0",      2'd0, 8'h01, 32'h0000_0000, 32'h0000_0419, 1'b0);
      run_one("tanh_p1",     2'd0, 8'h02, 32'h0001_0000, 32'h0000_BE90, 1'b0);
      run_one("tanh_m1",     2'd0, 8'h03, 32'hFFFF_0000, 32'hFFFF_4170, 1'b0);
      run_one("tanh_p3",     2'd0, 8'h04, 32'h0003_0000, 32'h0001_0000, 1'b0);
      run_one("tanh_min",    2'd0, 8'h05, 32'h8000_0000, 32'hFFFF_0000, 1'b1);
      run_one("tanh_at_A",   2'd0, 8'h06, 32'h0001_851F, 32'h0000_E891, 1'b0);
      run_one("tanh_p2",     2'd0, 8'h07, 32'h0002_0000, 32'h0000_F744, 1'b0);
      run_one("sig_0",       2'd1, 8'h08, 32'h0000_0000, 32'h0000_820C, 1'b0);
      run_one("sig_p2",      2'd1, 8'h09, 32'h0002_0000, 32'h0000_DF48, 1'b0);
      run_one("relu_neg",    2'd2, 8'h0A, 32'hFFFD_0000, 32'h0000_0000, 1'b0);
      run_one("relu_pos",    2'd2, 8'h0B, 32'h0002_8000, 32'h0002_8000, 1'b0);
      run_one("ident",       2'd3, 8'h0C, 32'h1234_5678, 32'h1234_5678, 1'b0);
      run_one("ident_min",   2'd3, 8'h0D, 32'h8000_0000, 32'h8000_0000, 1'b0);

      bp_mode[0] = 2'd0; bp_x[0] = 32'h0000_0000; bp_y[0] = 32'h0000_0419;
      bp_mode[1] = 2'd1; bp_x[1] = 32'h0000_0000; bp_y[1] = 32'h0000_820C;
      bp_mode[2] = 2'd2; bp_x[2] = 32'hFFFD_0000; bp_y[2] = 32'h0000_0000;
      bp_mode[3] = 2'd3; bp_x[3] = 32'h1234_5678; bp_y[3] = 32'h1234_5678;
      bp_mode[4] = 2'd0; bp_x[4] = 32'h0001_0000; bp_y[4] = 32'h0000_BE90;
      bp_mode[5] = 2'd0; bp_x[5] = 32'hFFFF_0000; bp_y[5] = 32'hFFFF_4170;
      bp_mode[6] = 2'd2; bp_x[6] = 32'h0002_8000; bp_y[6] = 32'h0002_8000;
      bp_mode[7] = 2'd0; bp_x[7] = 32'h0003_0000; bp_y[7] = 32'h0001_0000;
      bp_mode[8] = 2'd1; bp_x[8] = 32'h0002_0000; bp_y[8] = 32'h0000_DF48;
      bp_mode[9] = 2'd0; bp_x[9] = 32'h0002_0000; bp_y[9] = 32'h0000_F744;

      lfsr = 8'hA5; held = 1'b0; held_y = '0; held_tag = '0; tx = 0; rx = 0;
      for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
         @(negedge clk);
         if (held) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_y", y, held_y);
            check("bp_hold_tag", out_tag, held_tag);
         end
         out_ready = lfsr[0] | lfsr[2];
         lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         in_valid  = (tx < 10);
         if (tx < 10) begin
            in_mode = bp_mode[tx];
            in_tag  = 8'(tx);
            x       = bp_x[tx];
         end
         #1;
         check("bp_in_ready", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            check("bp_tag", out_tag, 8'(rx));
            check("bp_y", y, bp_y[rx]);
            rx++;
         end
         if (in_valid && in_ready) tx++;
         held     = out_valid && !out_ready;
         held_y   = y;
         held_tag = out_tag;
      end
      check("bp_count", rx, 10);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("bp_no_dup", extra, 0);

      // Reset with three samples in flight, the oldest stalled at the output.
      @(negedge clk);
      in_valid = 1'b1; in_mode = 2'd3; in_tag = 8'hA0; x = 32'h0000_00A0; out_ready = 1'b0;
      @(negedge clk);
      in_tag = 8'hA1; x = 32'h0000_00A1;
      @(negedge clk);
      in_tag = 8'hA2; x = 32'h0000_00A2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_full_valid", out_valid, 1);
      check("mid_full_tag", out_tag, 8'hA0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_y", y, 0);
      check("mid_rst_tag", out_tag, 0);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("mid_no_ghost", extra, 0);
      run_one("post_rst", 2'd3, 8'hB0, 32'h0000_0055, 32'h0000_0055, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
